// File: rtl/fir_coef_loader.sv
// +-----------------------------------------------------------------------------+
// | fir_coef_loader : streams a coefficient set into a shadow bank, swaps it    |
// | onto the FIR at a sample strobe, then holds out_valid low until flushed.    |
// | Option macro FIR_COEF_LOADER_IMPULSE_EN: reset to a unit-impulse set.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fir_coef_loader #(
   parameter int TAPS = 27,
   parameter int CW   = 32,
   parameter int LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [CW-1:0]        wr_data,
   input  logic                 wr_last,
   input  logic                 sample_en,
   output logic [TAPS*CW-1:0]   coefs,
   output logic                 out_valid,
   output logic                 busy,
   output logic                 err
);

   localparam int c_IDX_W = $clog2(TAPS);
   localparam int c_CNT_W = $clog2(TAPS + LAT + 1);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(TAPS - 1);
   localparam logic [c_CNT_W-1:0] c_FLUSH_INIT = c_CNT_W'(TAPS + LAT - 1);

`ifdef FIR_COEF_LOADER_IMPULSE_EN
   localparam logic [TAPS*CW-1:0] c_COEF_RST =
      {{(CW-1){1'b0}}, 1'b1, {((TAPS-1)*CW){1'b0}}};
`else
   localparam logic [TAPS*CW-1:0] c_COEF_RST = '0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_PEND  = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic                 w_xfer;
   logic                 w_wr_shadow;
   logic                 w_swap;
   logic                 w_valid_rise;
   logic                 w_err_nxt;
   logic [CW-1:0]        r_shadow [TAPS];
   logic [TAPS*CW-1:0]   w_shadow_flat;
   logic [TAPS*CW-1:0]   r_coefs;
   logic                 r_out_valid;
   logic                 r_err;

   assign wr_ready  = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign w_xfer    = wr_valid & wr_ready;
   assign busy      = (r_state != S_IDLE);
   assign coefs     = r_coefs;
   assign out_valid = r_out_valid;
   assign err       = r_err;

   // Shadow word 0 is tap 0, which lands in the most-significant slice.
   for (genvar i = 0; i < TAPS; i++) begin : g_flat
      assign w_shadow_flat[(TAPS-1-i)*CW +: CW] = r_shadow[i];
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = r_cnt;
      w_wr_shadow  = 1'b0;
      w_swap       = 1'b0;
      w_valid_rise = 1'b0;
      w_err_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_wr_shadow = 1'b1;
               if (wr_last) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_idx_nxt   = c_IDX_W'(1);
                  w_state_nxt = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (w_xfer) begin
               w_wr_shadow = 1'b1;
               if (r_idx == c_LAST_IDX) begin
                  w_idx_nxt = '0;
                  if (wr_last) begin
                     w_state_nxt = S_PEND;
                  end else begin
                     w_err_nxt   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end else if (wr_last) begin
                  w_idx_nxt   = '0;
                  w_err_nxt   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_idx_nxt = r_idx + c_IDX_W'(1);
               end
            end
         end
         S_PEND: begin
            if (sample_en) begin
               w_swap      = 1'b1;
               w_cnt_nxt   = c_FLUSH_INIT;
               w_state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // The FIR shifts every clock, so the flush ignores sample_en.
            if (r_cnt == '0) begin
               w_valid_rise = 1'b1;
               w_state_nxt  = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - c_CNT_W'(1);
            end
         end
         default: begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
`ifdef FIR_COEF_LOADER_IMPULSE_EN
         r_state <= S_FLUSH;
         r_cnt   <= c_FLUSH_INIT;
`else
         r_state <= S_IDLE;
         r_cnt   <= '0;
`endif
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TAPS; i++) begin
            r_shadow[i] <= '0;
         end
         r_coefs     <= c_COEF_RST;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_wr_shadow) begin
            r_shadow[r_idx] <= wr_data;
         end
         if (w_swap) begin
            r_coefs <= w_shadow_flat;
         end
         if (w_swap) begin
            r_out_valid <= 1'b0;
         end else if (w_valid_rise) begin
            r_out_valid <= 1'b1;
         end
         r_err <= w_err_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
// Bench for fir_coef_loader: a queue-based model of the set/swap/flush rules is
// compared every cycle, plus directed literal checks on the named scenarios.
`default_nettype none

module tb_fir_coef_loader;

   localparam int TAPS = 27;
   localparam int CW   = 32;
   localparam int LAT  = 2;
   localparam int FW   = TAPS * CW;

   logic            tb_clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            wr_valid = 1'b0;
   logic            wr_last = 1'b0;
   logic            sample_en = 1'b0;
   logic [CW-1:0]   wr_data = '0;
   logic            wr_ready;
   logic [FW-1:0]   coefs;
   logic            out_valid;
   logic            busy;
   logic            err;

   int checks = 0;
   int errors = 0;

   fir_coef_loader #(.TAPS(TAPS), .CW(CW), .LAT(LAT)) dut (
      .clk       (tb_clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .wr_last   (wr_last),
      .sample_en (sample_en),
      .coefs     (coefs),
      .out_valid (out_valid),
      .busy      (busy),
      .err       (err)
   );

   always #5 tb_clk = ~tb_clk;

   task automatic chkw(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @%0t got=%0h exp=%0h", name, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] ms_tap(input logic [FW-1:0] c);
      return 32'(c[FW-1 -: CW]);
   endfunction

   function automatic logic [31:0] ls_tap(input logic [FW-1:0] c);
      return 32'(c[CW-1:0]);
   endfunction

   // ---------------- reference model ----------------
   logic [CW-1:0] m_words[$];
   logic [FW-1:0] m_shadow;
   logic [FW-1:0] m_coefs;
   bit            m_pending;
   bit            m_ov;
   bit            m_err;
   int            m_flush;   // edges still to come before out_valid rises

   task automatic model_reset();
      m_words.delete();
      m_shadow  = '0;
      m_pending = 1'b0;
      m_ov      = 1'b0;
      m_err     = 1'b0;
`ifdef FIR_COEF_LOADER_IMPULSE_EN
      m_coefs = '0;
      m_coefs[FW-1 -: CW] = CW'(1);
      m_flush = TAPS + LAT;
`else
      m_coefs = '0;
      m_flush = 0;
`endif
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge tb_clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            m_err = 1'b0;
            if (m_flush > 0) begin
               m_flush--;
               if (m_flush == 0) m_ov = 1'b1;
            end else if (m_pending) begin
               if (sample_en) begin
                  m_coefs   = m_shadow;
                  m_ov      = 1'b0;
                  m_flush   = TAPS + LAT;
                  m_pending = 1'b0;
               end
            end else if (wr_valid) begin
               m_words.push_back(wr_data);
               if (wr_last && m_words.size() == TAPS) begin
                  for (int i = 0; i < TAPS; i++) m_shadow[(TAPS-1-i)*CW +: CW] = m_words[i];
                  m_pending = 1'b1;
                  m_words.delete();
               end else if (wr_last || m_words.size() == TAPS) begin
                  m_err = 1'b1;
                  m_words.delete();
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge tb_clk);
         chkv("cyc_ready", 32'(wr_ready), 32'(!m_pending && m_flush == 0));
         chkv("cyc_busy", 32'(busy), 32'(m_words.size() > 0 || m_pending || m_flush > 0));
         chkv("cyc_err", 32'(err), 32'(m_err));
         chkv("cyc_out_valid", 32'(out_valid), 32'(m_ov));
         chkw("cyc_coefs", coefs, m_coefs);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge tb_clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wait_not_busy();
      int g;
      for (g = 0; g < 100 && busy; g++) step();
      chkv("busy_timeout", 32'(busy), 32'(0));
   endtask

   task automatic send_set(input int n, input int base, input bit last_on_final, input bit strobe_on_final);
      bit rdy;
      int g;
      for (int i = 0; i < n; i++) begin
         wr_valid  = 1'b1;
         wr_data   = CW'(base + i);
         wr_last   = (i == n - 1) && last_on_final;
         sample_en = (i == n - 1) && strobe_on_final;
         g = 0;
         do begin
            rdy = wr_ready;
            step();
            g++;
         end while (!rdy && g < 100);
         if (!rdy) chkv("ready_timeout", 32'(rdy), 32'(1));
      end
      wr_valid  = 1'b0;
      wr_last   = 1'b0;
      sample_en = 1'b0;
      wr_data   = '0;
   endtask

   task automatic strobe();
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
   endtask

   // Counts sampled cycles with out_valid low, starting at the next negedge.
   task automatic wait_valid(output int n);
      for (n = 0; n < 100; n++) begin
         @(negedge tb_clk);
         if (out_valid) break;
      end
      chkv("valid_timeout", 32'(n < 100), 32'(1));
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int n;
      rst_n = 1'b0;
      @(negedge tb_clk);
      chkv("rst_out_valid", 32'(out_valid), 32'(0));
      chkv("rst_err", 32'(err), 32'(0));
`ifndef FIR_COEF_LOADER_IMPULSE_EN
      chkw("rst_coefs", coefs, '0);
      chkv("rst_busy", 32'(busy), 32'(0));
      chkv("rst_ready", 32'(wr_ready), 32'(1));
`endif
      idle(2);
      rst_n = 1'b1;
      wait_not_busy();

      // Full set 1..27, strobe after 5 idle cycles.
      send_set(TAPS, 1, 1'b1, 1'b0);
      idle(5);
      strobe();
      wait_valid(n);
      chkv("t1_low_cycles", 32'(n), 32'(29));
      chkv("t1_busy_fall", 32'(busy), 32'(0));
      chkv("t1_ms_tap", ms_tap(coefs), 32'd1);
      chkv("t1_ls_tap", ls_tap(coefs), 32'd27);
      step();

      // Short set: last on word 10.
      send_set(10, 100, 1'b1, 1'b0);
      @(negedge tb_clk);
      chkv("t2_err_pulse", 32'(err), 32'(1));
      chkv("t2_ready", 32'(wr_ready), 32'(1));
      chkv("t2_ls_kept", ls_tap(coefs), 32'd27);
      @(negedge tb_clk);
      chkv("t2_err_clear", 32'(err), 32'(0));
      step();

      // Full-length set without wr_last.
      send_set(TAPS, 200, 1'b0, 1'b0);
      @(negedge tb_clk);
      chkv("t3_err_pulse", 32'(err), 32'(1));
      step();
      strobe();
      idle(2);
      @(negedge tb_clk);
      chkv("t3_no_swap", ls_tap(coefs), 32'd27);
      chkv("t3_busy", 32'(busy), 32'(0));
      chkv("t3_out_valid", 32'(out_valid), 32'(1));
      step();

      // Strobe coincident with last word is ignored; the later one swaps.
      send_set(TAPS, 300, 1'b1, 1'b1);
      @(negedge tb_clk);
      chkv("t4_pending", 32'(busy), 32'(1));
      chkv("t4_no_early_swap", ls_tap(coefs), 32'd27);
      step();
      idle(1);
      strobe();
      wait_valid(n);
      chkv("t4_low_cycles", 32'(n), 32'(29));
      chkv("t4_ms_tap", ms_tap(coefs), 32'd300);
      chkv("t4_ls_tap", ls_tap(coefs), 32'd326);
      step();

      // Reset in mid-flush, then a normal reload.
      send_set(TAPS, 400, 1'b1, 1'b0);
      strobe();
      idle(16);
      rst_n = 1'b0;
      @(negedge tb_clk);
      chkv("t5_rst_out_valid", 32'(out_valid), 32'(0));
      chkv("t5_rst_err", 32'(err), 32'(0));
`ifndef FIR_COEF_LOADER_IMPULSE_EN
      chkw("t5_rst_coefs", coefs, '0);
      chkv("t5_rst_busy", 32'(busy), 32'(0));
`endif
      step();
      rst_n = 1'b1;
      wait_not_busy();
      send_set(TAPS, 500, 1'b1, 1'b0);
      strobe();
      wait_valid(n);
      chkv("t5_low_cycles", 32'(n), 32'(29));
      chkv("t5_ms_tap", ms_tap(coefs), 32'd500);
      chkv("t5_ls_tap", ls_tap(coefs), 32'd526);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Controller that owns the flat coefficient bus of one fir instance and reloads it at run time without corrupting the sample stream.
- Receives coefficients as a valid/ready word stream into a shadow bank and checks the set length.
- Swaps the bank onto the FIR at a sample-boundary strobe, then flags FIR output invalid until the delay line holds only post-swap results.
- Sits between a host/config port and the fir block; one loader per fir instance.

Parameters:
- TAPS, 27, number of FIR taps; must be >= 2.
- CW, 32, coefficient width in bits (signed).
- LAT, 2, FIR pipeline latency in clk cycles from the in port to the out port.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  coefficient word valid.
- wr_ready  out  1  loader accepts a word this cycle.
- wr_data  in  CW  signed coefficient; first word of a set is tap 0.
- wr_last  in  1  marks the final word of a set.
- sample_en  in  1  sample-boundary strobe; the swap is permitted only here.
- coefs  out  TAPS*CW  flat bus to fir; tap 0 occupies the MS slice [TAPS*CW-1 -: CW], tap TAPS-1 occupies the LS slice.
- out_valid  out  1  FIR output reflects only the current coefficient set.
- busy  out  1  a set is loading, pending, or flushing.
- err  out  1  one-cycle pulse when a malformed set is discarded.

Behaviour:
Reset (async, rst_n=0):
- coefs=0, shadow=0, out_valid=0, busy=0, err=0, state=IDLE, word index=0, flush counter=0.
- Reset mid-load or mid-flush drops everything; any partial set is lost.

Handshake:
- A word transfers when wr_valid & wr_ready on a clk edge.
- wr_ready=1 in IDLE and LOAD, 0 in PEND and FLUSH.
- wr_ready does not depend combinationally on wr_valid.

FSM:
- IDLE: on transfer, write shadow[0].
  - wr_last=1 on this word: err pulse, go to IDLE.
  - Otherwise: index=1, go to LOAD.
- LOAD: on transfer, write shadow[index].
  - index==TAPS-1 and wr_last=1: go to PEND.
  - index==TAPS-1 and wr_last=0: err pulse, discard, go to IDLE.
  - index<TAPS-1 and wr_last=1: err pulse, discard, go to IDLE.
  - Otherwise: index+1.
  - No transfer: hold state.
- PEND: wait for sample_en=1.
  - On that edge: coefs<=shadow, out_valid<=0, flush counter<=TAPS+LAT-1, go to FLUSH.
  - sample_en in the same cycle as the last word's transfer does not swap; the next strobe does.
- FLUSH: counter decrements every clk (fir shifts every clk).
  - At counter==0: out_valid<=1, go to IDLE.
  - Result: out_valid=0 for exactly TAPS+LAT cycles after the swap edge.
  - sample_en is ignored.

Outputs and arithmetic:
- busy=1 in LOAD, PEND, FLUSH.
- coefs change only on the swap edge (or on reset); they never show a partial set.
- Discarding a set leaves coefs and out_valid unchanged.
- Index width: $clog2(TAPS). Flush counter width: $clog2(TAPS+LAT+1).
- Values are stored verbatim; no scaling or saturation.

Optional Feature:
- Macro: FIR_COEF_LOADER_IMPULSE_EN.
- Defined:
  - Reset loads coefs with a unit impulse: tap 0 = 1, all others 0. FIR is a pass-through.
  - Reset enters FLUSH with counter=TAPS+LAT-1, so out_valid rises TAPS+LAT cycles after rst_n deasserts.
  - busy=1 during that flush.
- Undefined:
  - Reset coefs=0, state=IDLE, out_valid=0 until the first completed swap and flush.

Test Plan:
1. Reset, then stream 27 words 1..27 (last on 27th), then sample_en after 5 idle cycles -> coefs MS slice = 1 and LS slice = 27 on the swap edge; out_valid low 29 cycles, then high; busy falls together with out_valid's rise.
2. wr_last on the 10th word -> err high 1 cycle, state IDLE, coefs unchanged, wr_ready=1 next cycle.
3. 27 words with wr_last=0 on the 27th -> err pulse on that transfer, no swap even after sample_en.
4. sample_en asserted on the same edge as the 27th word, then again 3 cycles later -> swap occurs on the second strobe only.
5. Assert rst_n=0 during FLUSH (counter=12), release -> all outputs at reset values; a new 27-word set loads and swaps normally.
6. Compile with FIR_COEF_LOADER_IMPULSE_EN, drive the lowpass sine input -> out_valid rises 29 cycles after reset; fir out equals the input delayed by the FIR latency.
